// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice processes one operand
// bit per clock, LSB first, with valid/ready handshakes on both sides.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Handshake rule: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready/out_valid are registered and never depend on the partner.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              carry_q;
  logic [WIDTH-1:0]  sa_q;
  logic [WIDTH-1:0]  sb_q;
  logic [WIDTH-1:0]  res_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic              slice_s;
  logic              slice_c;
  logic [WIDTH-1:0]  res_d;

  assign slice_s = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign slice_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
  assign res_d   = {slice_s, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sa_q        <= '0;
      sb_q        <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            sa_q       <= op_a;
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            sb_q       <= sub ? ~op_b : op_b;
            carry_q    <= sub;
            cnt_q      <= '0;
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          res_q   <= res_d;
          carry_q <= slice_c;
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q       <= res_d;
            cout_q      <= slice_c;
            ovf_q       <= slice_c ^ carry_q;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): directed vectors plus a
// back-to-back random sweep against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         busy;
  logic [1:0]   state_dbg;

  logic [W+1:0] exp_q[$];
  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // {carry_out, overflow, sum} computed with plain integer arithmetic
  function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic s);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    if (s) begin
      r = a - b;
      c = (a >= b);
      v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      t = {1'b0, a} + {1'b0, b};
      r = t[W-1:0];
      c = t[W];
      v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {c, v, r};
  endfunction

  // monitor: pops one expectation per output transfer
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_result: got sum=%h c=%b v=%b with empty queue", sum, carry_out, overflow);
      end else begin
        e = exp_q.pop_front();
        check("result", {22'd0, carry_out, overflow, sum}, {22'd0, e});
      end
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [W+1:0] e);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    sub      = s;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W+1:0] e);
    int n = 0;
    out_ready = 1'b1;
    send(a, b, s, e);
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, W);
    @(posedge clk); #1;
    check("ready_after_unload", {31'd0, in_ready}, 32'd1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int prev_acc;
    int t;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;

    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b0;
    #1;
    check("reset_sum", {24'd0, sum}, 32'd0);
    check("reset_flags", {28'd0, carry_out, overflow, out_valid, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // timing + backpressure: 0x5A + 0x33 = 0x8D, c=0, v=1
    send(8'h5A, 8'h33, 1'b0, {2'b01, 8'h8D});
    for (int k = 1; k < W; k++) begin
      @(posedge clk); #1;
      check("early_valid", {31'd0, out_valid}, 32'd0);
      check("run_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    check("valid_at_E8", {31'd0, out_valid}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      op_a     = W'($urandom_range(0, 255));
      op_b     = W'($urandom_range(0, 255));
      sub      = k[0];
      @(posedge clk); #1;
      check("hold_result", {22'd0, carry_out, overflow, sum}, {22'd0, 2'b01, 8'h8D});
      check("hold_valid", {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_unload", {29'd0, out_valid, in_ready, busy}, 32'd2);
    check("bp_queue_drained", exp_q.size(), 0);

    run_op(8'hFF, 8'h01, 1'b0, {2'b10, 8'h00});
    run_op(8'h10, 8'h20, 1'b1, {2'b00, 8'hF0});
    run_op(8'h80, 8'h01, 1'b1, {2'b11, 8'h7F});

    // reset in the middle of a run
    out_ready = 1'b1;
    send(8'h77, 8'h11, 1'b0, {2'b00, 8'h88});
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrun_reset_sum", {24'd0, sum}, 32'd0);
    check("midrun_reset_flags", {28'd0, carry_out, overflow, out_valid, busy}, 32'd0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midrun_reset", {31'd0, in_ready}, 32'd1);
    run_op(8'h01, 8'h02, 1'b0, {2'b00, 8'h03});

    // back-to-back random sweep
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev_acc  = 0;
    for (int i = 0; i < 1000; i++) begin
      t = 0;
      while (!in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!in_ready) begin
        check("b2b_accept_timeout", 32'd0, 32'd1);
        break;
      end
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      op_a = a; op_b = b; sub = s;
      exp_q.push_back(model(a, b, s));
      @(posedge clk); #1;
      if (i > 0) check("b2b_period", cyc - prev_acc, W + 2);
      prev_acc = cyc;
    end
    in_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("final_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
